// File: rtl/march_bist.sv
// March C- memory BIST over NBG data backgrounds, wrapped around a single-port RAM.
// Define BIST_DIAG_EN to capture the address, element and background of the first mismatch.
module march_bist #(
  parameter int AW  = 6,
  parameter int DW  = 8,
  parameter int NBG = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          csin,
  input  logic          rwbarin,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] datain,
  output logic [DW-1:0] dataout,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [1:0]    fail_bg
);

  localparam int         DEPTH   = 1 << AW;
  localparam logic [1:0] BG_LAST = 2'(NBG - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DN} state_t;

  state_t        state;
  logic [2:0]    elem;
  logic [1:0]    bg;
  logic [AW-1:0] cnt;
  logic          ph;
  logic [DW-1:0] exp_q;
  logic          cmp_vld;

  logic [DW-1:0] mem [DEPTH];

  function automatic logic [DW-1:0] bg_pat(input logic [1:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < DW; j++) begin
      if (b != 2'd0) r[j] = ((j >> (int'(b) - 1)) & 1) != 0;
    end
    return r;
  endfunction

  logic [DW-1:0] pat0;
  logic [AW-1:0] eng_addr;
  logic          eng_rd;
  logic [DW-1:0] eng_wdat;
  logic [DW-1:0] eng_exp;
  logic          last_op;
  logic          mismatch;

  assign pat0     = bg_pat(bg);
  // M3/M4 walk downwards; the counter always counts up and is mirrored here.
  assign eng_addr = (elem == 3'd3 || elem == 3'd4) ? ~cnt : cnt;
  assign mismatch = cmp_vld && (dataout != exp_q);

  always_comb begin
    eng_rd   = 1'b0;
    eng_wdat = pat0;
    eng_exp  = pat0;
    last_op  = 1'b1;
    case (elem)
      3'd0: begin
        eng_rd   = 1'b0;
        eng_wdat = pat0;
      end
      3'd1, 3'd3: begin
        eng_rd   = !ph;
        eng_exp  = pat0;
        eng_wdat = ~pat0;
        last_op  = ph;
      end
      3'd2, 3'd4: begin
        eng_rd   = !ph;
        eng_exp  = ~pat0;
        eng_wdat = pat0;
        last_op  = ph;
      end
      default: begin
        eng_rd  = 1'b1;
        eng_exp = pat0;
      end
    endcase
  end

  logic          ram_cs;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdat;

  assign ram_cs   = busy ? (state == RUN) : csin;
  assign ram_rd   = busy ? eng_rd : rwbarin;
  assign ram_addr = busy ? eng_addr : address;
  assign ram_wdat = busy ? eng_wdat : datain;

  always_ff @(posedge clk) begin
    if (ram_cs && !ram_rd) mem[ram_addr] <= ram_wdat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dataout <= '0;
    else if (ram_cs && ram_rd) dataout <= mem[ram_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      elem    <= '0;
      bg      <= '0;
      cnt     <= '0;
      ph      <= 1'b0;
      exp_q   <= '0;
      cmp_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      cmp_vld <= 1'b0;
      if (mismatch) fail <= 1'b1;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            fail  <= 1'b0;
            elem  <= '0;
            bg    <= '0;
            cnt   <= '0;
            ph    <= 1'b0;
          end
        end
        RUN: begin
          if (eng_rd) begin
            exp_q   <= eng_exp;
            cmp_vld <= 1'b1;
          end
          if (!last_op) begin
            ph <= 1'b1;
          end else begin
            ph <= 1'b0;
            if (&cnt) begin
              cnt <= '0;
              if (elem == 3'd5) begin
                elem <= '0;
                if (bg == BG_LAST) state <= FLUSH;
                else bg <= bg + 2'd1;
              end else begin
                elem <= elem + 3'd1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          state <= DN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BIST_DIAG_EN
  logic [AW-1:0] tag_addr;
  logic [2:0]    tag_elem;
  logic [1:0]    tag_bg;

  // Tags ride alongside exp_q so a mismatch seen a cycle later still knows its origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_addr <= '0;
      tag_elem <= '0;
      tag_bg   <= '0;
    end else if (state == RUN && eng_rd) begin
      tag_addr <= eng_addr;
      tag_elem <= elem;
      tag_bg   <= bg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_addr <= '0;
      fail_elem <= '0;
      fail_bg   <= '0;
    end else if (state == IDLE && start) begin
      fail_addr <= '0;
      fail_elem <= '0;
      fail_bg   <= '0;
    end else if (mismatch && !fail) begin
      fail_addr <= tag_addr;
      fail_elem <= tag_elem;
      fail_bg   <= tag_bg;
    end
  end
`else
  assign fail_addr = '0;
  assign fail_elem = '0;
  assign fail_bg   = '0;
`endif

endmodule

// File: tb/tb_march_bist.sv
// Scoreboard bench for march_bist: normal access, golden, fault, interference and reset-abort runs.
module tb_march_bist;
  localparam int AW      = 6;
  localparam int DW      = 8;
  localparam int NBG     = 4;
  localparam int RUN_CYC = NBG * 10 * (1 << AW) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          csin = 1'b0;
  logic          rwbarin = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] datain = '0;
  logic [DW-1:0] dataout;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [1:0]    fail_bg;

  march_bist #(.AW(AW), .DW(DW), .NBG(NBG)) dut (
    .clk(clk), .rst(rst), .start(start), .csin(csin), .rwbarin(rwbarin),
    .address(address), .datain(datain), .dataout(dataout), .busy(busy),
    .done(done), .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem),
    .fail_bg(fail_bg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          f;
    logic [AW-1:0] a;
    logic [2:0]    e;
    logic [1:0]    b;
  } exp_t;

  exp_t          done_q[$];
  logic [DW-1:0] rd_q[$];
  logic          rd_pend = 1'b0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            busy_cnt = 0;

`ifdef BIST_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read result or a done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (rd_pend) begin
        rd_pend = 1'b0;
        if (rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else check("rd_data", 64'(dataout), 64'(rd_q.pop_front()));
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = done_q.pop_front();
          check("fail_at_done", 64'(fail), 64'(e.f));
          check("fail_addr", 64'(fail_addr), 64'(e.a));
          check("fail_elem", 64'(fail_elem), 64'(e.e));
          check("fail_bg", 64'(fail_bg), 64'(e.b));
          check("busy_len", 64'(busy_cnt), 64'(RUN_CYC));
          check("busy_in_done", 64'(busy), 64'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic sys_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    csin = 1'b1; rwbarin = 1'b0; address = a; datain = d;
    @(posedge clk); #1;
    csin = 1'b0;
  endtask

  task automatic sys_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    csin = 1'b1; rwbarin = 1'b1; address = a;
    rd_q.push_back(exp);
    @(posedge clk); #1;
    csin = 1'b0;
    rd_pend = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic start_run(input bit push, input exp_t e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) done_q.push_back(e);
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t pass_e;
    exp_t fault_e;
    pass_e  = '{f: 1'b0, a: '0, e: 3'd0, b: 2'd0};
    fault_e = '{f: 1'b1, a: DIAG ? 6'h2A : 6'h00, e: DIAG ? 3'd1 : 3'd0, b: 2'd0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_dataout", 64'(dataout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fail", 64'(fail), 64'd0);
    check("rst_fail_addr", 64'(fail_addr), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    sys_write(6'h03, 8'hA5);
    sys_read(6'h03, 8'hA5);
    check("normal_busy", 64'(busy), 64'd0);
    check("normal_fail", 64'(fail), 64'd0);
    sys_write(6'h0A, 8'h3C);
    sys_write(6'h0B, 8'hC3);
    sys_read(6'h0A, 8'h3C);
    sys_read(6'h0B, 8'hC3);

    // Golden run leaves every word at the last background "0" data.
    start_run(1'b1, pass_e);
    wait_done(RUN_CYC + 20);
    sys_read(6'h05, 8'hF0);
    sys_read(6'h3F, 8'hF0);

    // Corrupt the M1/bg0 read of 0x2A (RUN cycle 148) in its compare cycle 149.
    start_run(1'b1, fault_e);
    repeat (149) @(posedge clk);
    #1;
    force dut.dataout = 8'h08;
    @(posedge clk); #1;
    release dut.dataout;
    wait_done(RUN_CYC + 20);
    check("fail_sticky_idle", 64'(fail), 64'd1);

    // Start and system writes during the run must be ignored.
    start_run(1'b1, pass_e);
    repeat (1199) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1299) @(posedge clk);
    #1;
    csin = 1'b1; rwbarin = 1'b0; address = 6'h05; datain = 8'h77;
    repeat (10) @(posedge clk);
    #1;
    csin = 1'b0;
    wait_done(RUN_CYC + 20);
    sys_read(6'h05, 8'hF0);

    // Reset mid-run, then a full rerun.
    start_run(1'b0, pass_e);
    repeat (999) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_fail", 64'(fail), 64'd0);
    check("midrst_dataout", 64'(dataout), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_run(1'b1, pass_e);
    wait_done(RUN_CYC + 20);

    repeat (4) @(posedge clk);
    check("pending_done", 64'(done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
